// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan driver: digit count,
// all-off drive levels and the active-low hex glyph table.
package ss_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bus is active-low with ss[0]=a .. ss[6]=g; all-high is dark.
  localparam logic [6:0] SS_OFF  = 7'h7F;
  // Digit selects are active-low; all-high deselects every digit.
  localparam logic [3:0] DIG_OFF = 4'hF;

  typedef logic [6:0] glyph_t;

  // Active-low glyphs for 0..F (A, b, C, d, E, F use the usual mixed case).
  localparam glyph_t GLYPH_TABLE [16] = '{
    7'h40,  // 0
    7'h79,  // 1
    7'h24,  // 2
    7'h30,  // 3
    7'h19,  // 4
    7'h12,  // 5
    7'h02,  // 6
    7'h78,  // 7
    7'h00,  // 8
    7'h10,  // 9
    7'h08,  // A
    7'h03,  // b
    7'h46,  // C
    7'h21,  // d
    7'h06,  // E
    7'h0E   // F
  };

endpackage

// File: rtl/ss_hex_decode.sv
// Combinational hex-nibble to active-low seven-segment glyph decoder.
module ss_hex_decode
  import ss_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH_TABLE[i_nib];

endmodule

// File: rtl/ss_scan_drv.sv
// Four-digit multiplexed seven-segment scan driver.
// A slot counter divides the clock into digit slots, each opening with a
// dead-time blank; the shown value only changes on frame boundaries so a
// digit sweep never mixes old and new data.
// Optional build macro: SS_LEADING_ZERO_BLANK_EN enables leading-zero
// suppression on digits 4..2 (digit 1 always shows its nibble).
// SCAN_DIV must be at least 2 and BLANK_CYC must be below SCAN_DIV.
module ss_scan_drv
  import ss_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [15:0] data,
  input  logic        load,
  output logic        busy,
  output logic        frame,
  output logic [6:0]  ss,
  output logic [3:0]  dig
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [1:0]       IDX_LAST  = 2'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_pend_val;
  logic             r_pend;
  logic [15:0]      r_disp;
  logic             r_frame;
  logic [6:0]       r_ss;
  logic [3:0]       r_dig;

  logic             w_wrap;
  logic             w_bnd;
  logic             w_blank;
  logic [3:0]       w_nib;
  logic [6:0]       w_glyph;
  logic             w_lz_blank;

  assign w_wrap  = (r_cnt == CNT_LAST);
  assign w_bnd   = w_wrap && (r_idx == IDX_LAST);
  assign w_blank = (r_cnt < CNT_BLANK);

  // Slot counter and round-robin digit index.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Pending/display registers: loads park in the pending register and are
  // committed to the display only at a frame boundary; a load that lands
  // on the boundary itself bypasses the stale pending value.
  // NOTE: the value registers are reset too, so the display reliably shows
  // 0000 after reset and a reset discards whatever was pending.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_pend_val <= '0;
      r_pend     <= 1'b0;
      r_disp     <= '0;
    end else if (w_bnd) begin
      if (load) begin
        r_disp <= data;
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_disp <= r_pend_val;
        r_pend <= 1'b0;
      end
    end else if (load) begin
      r_pend_val <= data;
      r_pend     <= 1'b1;
    end
  end

  // Select the nibble of the display register belonging to the active digit.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_nib = r_disp[3:0];
    case (r_idx)
      2'd1:    w_nib = r_disp[7:4];
      2'd2:    w_nib = r_disp[11:8];
      2'd3:    w_nib = r_disp[15:12];
      default: w_nib = r_disp[3:0];
    endcase
  end

  ss_hex_decode u_hex_decode (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  // Leading-zero suppression: a digit goes dark when it and every more
  // significant nibble are zero; digit 1 always shows its nibble.
  always_comb begin
    w_lz_blank = 1'b0;
`ifdef SS_LEADING_ZERO_BLANK_EN
    case (r_idx)
      2'd3:    w_lz_blank = (r_disp[15:12] == 4'h0);
      2'd2:    w_lz_blank = (r_disp[15:8]  == 8'h00);
      2'd1:    w_lz_blank = (r_disp[15:4]  == 12'h000);
      default: w_lz_blank = 1'b0;
    endcase
`endif
  end

  // Registered segment/digit drive and frame pulse, one cycle behind cnt/idx.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_ss    <= SS_OFF;
      r_dig   <= DIG_OFF;
      r_frame <= 1'b0;
    end else begin
      r_frame <= w_bnd;
      if (w_blank) begin
        r_ss  <= SS_OFF;
        r_dig <= DIG_OFF;
      end else begin
        r_ss  <= w_lz_blank ? SS_OFF : w_glyph;
        r_dig <= ~(4'b0001 << r_idx);
      end
    end
  end

  assign ss    = r_ss;
  assign dig   = r_dig;
  assign frame = r_frame;
  assign busy  = r_pend;

endmodule
